// File: rtl/led_cube_pkg.sv
// rtl/led_cube_pkg.sv - shared controller mode encoding for the LED cube
package led_cube_pkg;

   // Controller operating modes; the frame buffer is live only in streaming
   typedef enum logic [3:0] {
      MODE_OFF     = 4'h0,
      MODE_TEST    = 4'h1,
      MODE_PATTERN = 4'h2,
      MODE_STREAM  = 4'h3
   } cube_mode_e;

   localparam logic [3:0] STREAM_MODE = MODE_STREAM;

endpackage

// File: rtl/led_cube_frame_ram.sv
// rtl/led_cube_frame_ram.sv - simple dual-port frame storage RAM
module led_cube_frame_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // No reset on the array so it maps onto block RAM
   logic [DATA_W-1:0] mem [DEPTH];

   // Synchronous write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port, one cycle of latency
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/led_cube_frame_fifo.sv
// rtl/led_cube_frame_fifo.sv - multi-frame UART stream buffer feeding the cube scan logic
module led_cube_frame_fifo
   import led_cube_pkg::*;
#(
   parameter int         DATA_W      = 8,
   parameter int         FRAME_BYTES = 64,
   parameter int         NUM_FRAMES  = 8,
   parameter logic [3:0] STREAM_MODE = MODE_STREAM,
   localparam int        AW          = $clog2(FRAME_BYTES),
   localparam int        FW          = $clog2(NUM_FRAMES),
   localparam int        CW          = $clog2(NUM_FRAMES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        mode,
   input  logic              new_data,
   input  logic [DATA_W-1:0] uart_reg,
   input  logic [AW-1:0]     frame_addr,
   input  logic              frame_done,
   output logic [DATA_W-1:0] data_to_latch,
   output logic [CW-1:0]     frame_count,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_FRAMES);
   localparam logic [CW-1:0] COUNT_ONE = CW'(1);
   localparam logic [AW-1:0] LAST_BYTE = AW'(FRAME_BYTES - 1);

   logic [AW-1:0]     wr_addr;
   logic [FW-1:0]     wr_frame;
   logic [FW-1:0]     rd_frame;
   logic [CW-1:0]     count;
   logic              rd_valid;
   logic [DATA_W-1:0] ram_rdata;

   logic flush;
   logic queue_full;
   logic do_write;
   logic do_commit;
   logic do_drop;
   logic do_release;

   // Decode this cycle's flush, write, commit, drop and release conditions
   always_comb begin
      flush      = ~rst_n | (mode != STREAM_MODE);
      queue_full = (count == COUNT_MAX);
      do_write   = new_data & ~queue_full;
      do_commit  = do_write & (wr_addr == LAST_BYTE);
      do_drop    = new_data & queue_full;
      do_release = frame_done & (count > COUNT_ONE);
   end

   // Write side: byte pointer and frame slot being filled
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_addr  <= '0;
         wr_frame <= '0;
      end else if (do_write) begin
         wr_addr <= wr_addr + 1'b1;
         if (do_commit) begin
            wr_frame <= wr_frame + 1'b1;
         end
      end
   end

   // Read side: displayed frame slot advances only when another frame is queued
   always_ff @(posedge clk) begin
      if (flush) begin
         rd_frame <= '0;
      end else if (do_release) begin
         rd_frame <= rd_frame + 1'b1;
      end
   end

   // Committed-frame occupancy; commit and release together cancel out
   always_ff @(posedge clk) begin
      if (flush) begin
         count <= '0;
      end else begin
         case ({do_commit, do_release})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky flag for any byte discarded while the queue was full
   always_ff @(posedge clk) begin
      if (flush) begin
         overflow <= 1'b0;
      end else if (do_drop) begin
         overflow <= 1'b1;
      end
   end

   // Qualifies the RAM read issued on the same edge; empty queue reads as zero
   always_ff @(posedge clk) begin
      if (flush) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= (count != '0);
      end
   end

   // Writes never target the displayed slot: wr_frame == rd_frame only when
   // empty (reads gated) or full (writes blocked)
   led_cube_frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (NUM_FRAMES * FRAME_BYTES)
   ) u_frame_ram (
      .clk   (clk),
      .we    (do_write & ~flush),
      .waddr ({wr_frame, wr_addr}),
      .wdata (uart_reg),
      .raddr ({rd_frame, frame_addr}),
      .rdata (ram_rdata)
   );

   assign data_to_latch = rd_valid ? ram_rdata : '0;
   assign frame_count   = count;
   assign full          = queue_full;
   assign empty         = (count == '0);

endmodule

// File: tb/tb_led_cube_frame_fifo.sv
// tb/tb_led_cube_frame_fifo.sv - directed self-checking bench for led_cube_frame_fifo
module tb_led_cube_frame_fifo;

   localparam int DATA_W      = 8;
   localparam int FRAME_BYTES = 64;
   localparam int NUM_FRAMES  = 8;
   localparam int AW          = 6;
   localparam int CW          = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        mode;
   logic              new_data;
   logic [DATA_W-1:0] uart_reg;
   logic [AW-1:0]     frame_addr;
   logic              frame_done;
   logic [DATA_W-1:0] data_to_latch;
   logic [CW-1:0]     frame_count;
   logic              full;
   logic              empty;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0]     addr;
      logic              done;
      logic [DATA_W-1:0] exp_data;
      logic [CW-1:0]     exp_count;
   } vec_t;

   vec_t sweep_vec [65];
   vec_t rot_vec   [4];

   always #5 clk = ~clk;

   led_cube_frame_fifo #(
      .DATA_W      (DATA_W),
      .FRAME_BYTES (FRAME_BYTES),
      .NUM_FRAMES  (NUM_FRAMES),
      .STREAM_MODE (4'h3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode          (mode),
      .new_data      (new_data),
      .uart_reg      (uart_reg),
      .frame_addr    (frame_addr),
      .frame_done    (frame_done),
      .data_to_latch (data_to_latch),
      .frame_count   (frame_count),
      .full          (full),
      .empty         (empty),
      .overflow      (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [DATA_W-1:0] b);
      new_data = 1'b1;
      uart_reg = b;
      tick();
      new_data = 1'b0;
   endtask

   task automatic send_fill(input logic [DATA_W-1:0] b, input int n);
      for (int i = 0; i < n; i++) send_byte(b);
   endtask

   task automatic send_ramp(input logic [DATA_W-1:0] base, input int n);
      for (int i = 0; i < n; i++) send_byte(base + 8'(i));
   endtask

   task automatic do_flush();
      mode = 4'h1;
      tick();
      mode = 4'h3;
   endtask

   task automatic pulse_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic read_at(input logic [AW-1:0] a, input logic [DATA_W-1:0] exp, input string name);
      frame_addr = a;
      tick();
      chk(name, 32'(data_to_latch), 32'(exp));
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      frame_addr = v.addr;
      frame_done = v.done;
      tick();
      frame_done = 1'b0;
      tick();
      chk({name, "_data"},  32'(data_to_latch), 32'(v.exp_data));
      chk({name, "_count"}, 32'(frame_count),   32'(v.exp_count));
   endtask

   task automatic check_idle(input string name);
      chk({name, "_data"},  32'(data_to_latch), 32'h0);
      chk({name, "_count"}, 32'(frame_count),   32'h0);
      chk({name, "_empty"}, 32'(empty),         32'h1);
      chk({name, "_full"},  32'(full),          32'h0);
      chk({name, "_ovf"},   32'(overflow),      32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         sweep_vec[i] = '{addr: AW'(i), done: 1'b0, exp_data: 8'(i), exp_count: 4'd1};
      end
      sweep_vec[64] = '{addr: 6'd10, done: 1'b1, exp_data: 8'd10, exp_count: 4'd1};
      rot_vec[0] = '{addr: 6'd5, done: 1'b0, exp_data: 8'h11, exp_count: 4'd3};
      rot_vec[1] = '{addr: 6'd5, done: 1'b1, exp_data: 8'h22, exp_count: 4'd2};
      rot_vec[2] = '{addr: 6'd5, done: 1'b1, exp_data: 8'h33, exp_count: 4'd1};
      rot_vec[3] = '{addr: 6'd5, done: 1'b1, exp_data: 8'h33, exp_count: 4'd1};

      rst_n      = 1'b0;
      mode       = 4'h3;
      new_data   = 1'b0;
      uart_reg   = '0;
      frame_addr = '0;
      frame_done = 1'b0;
      tick();
      tick();
      check_idle("reset");
      rst_n = 1'b1;

      // Single ramp frame, full address sweep, ignored frame_done
      send_ramp(8'h00, 64);
      chk("ramp_count", 32'(frame_count), 32'd1);
      chk("ramp_empty", 32'(empty), 32'd0);
      for (int i = 0; i < 65; i++) apply_vec(sweep_vec[i], $sformatf("sweep%0d", i));

      // Three queued frames rotated by frame_done, last one held
      do_flush();
      send_fill(8'h11, 64);
      send_fill(8'h22, 64);
      send_fill(8'h33, 64);
      for (int i = 0; i < 4; i++) apply_vec(rot_vec[i], $sformatf("rot%0d", i));

      // Fill the queue, overflow, then refill the freed slot
      do_flush();
      for (int f = 0; f < 8; f++) send_fill(8'h40 + 8'(f), 64);
      chk("q8_count", 32'(frame_count), 32'd8);
      chk("q8_full",  32'(full), 32'd1);
      chk("q8_ovf",   32'(overflow), 32'd0);
      send_fill(8'hEE, 5);
      chk("drop_ovf",   32'(overflow), 32'd1);
      chk("drop_count", 32'(frame_count), 32'd8);
      pulse_done();
      chk("rel_count", 32'(frame_count), 32'd7);
      chk("rel_full",  32'(full), 32'd0);
      read_at(6'd0, 8'h41, "rel_data");
      send_ramp(8'h80, 64);
      chk("refill_count", 32'(frame_count), 32'd8);
      for (int i = 0; i < 7; i++) pulse_done();
      chk("ninth_count", 32'(frame_count), 32'd1);
      read_at(6'd0,  8'h80, "ninth_b0");
      read_at(6'd4,  8'h84, "ninth_b4");
      read_at(6'd63, 8'hBF, "ninth_b63");
      chk("ninth_ovf", 32'(overflow), 32'd1);

      // Partial frame then mode change away flushes everything
      send_fill(8'h77, 40);
      mode = 4'h1;
      tick();
      check_idle("mode_flush");
      mode = 4'h3;
      pulse_done();
      chk("empty_done_count", 32'(frame_count), 32'd0);
      read_at(6'd0, 8'h00, "empty_done_data");
      send_ramp(8'h20, 64);
      chk("reentry_count", 32'(frame_count), 32'd1);
      read_at(6'd0,  8'h20, "reentry_b0");
      read_at(6'd39, 8'h47, "reentry_b39");
      read_at(6'd63, 8'h5F, "reentry_b63");

      // Commit and release on the same edge
      do_flush();
      send_fill(8'h51, 64);
      send_fill(8'h52, 64);
      send_fill(8'h53, 63);
      new_data   = 1'b1;
      uart_reg   = 8'h53;
      frame_done = 1'b1;
      tick();
      new_data   = 1'b0;
      frame_done = 1'b0;
      chk("both_count", 32'(frame_count), 32'd2);
      read_at(6'd0, 8'h52, "both_data");
      pulse_done();
      chk("both_after_count", 32'(frame_count), 32'd1);
      read_at(6'd0, 8'h53, "both_after_data");

      // Reset mid-stream with five frames queued
      do_flush();
      for (int f = 0; f < 5; f++) send_ramp(8'(f * 16), 64);
      send_fill(8'h99, 10);
      chk("pre_rst_count", 32'(frame_count), 32'd5);
      rst_n = 1'b0;
      tick();
      check_idle("mid_reset");
      rst_n = 1'b1;
      send_ramp(8'h60, 64);
      chk("post_rst_count", 32'(frame_count), 32'd1);
      read_at(6'd0, 8'h60, "post_rst_b0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
